// File: rtl/seq_playback_ctrl_pkg.sv
// Shared types and constants for the sequence playback controller.
package seq_playback_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StShow,
    StGap,
    StDone
  } state_e;

  typedef logic [1:0] color_t;

  localparam color_t ColorRed    = 2'b00;
  localparam color_t ColorGreen  = 2'b01;
  localparam color_t ColorBlue   = 2'b10;
  localparam color_t ColorYellow = 2'b11;

  // Lamp vector ordered {yellow, blue, green, red}.
  function automatic logic [3:0] color_onehot(color_t c);
    logic [3:0] oh;
    oh = 4'b0000;
    unique case (c)
      ColorRed:    oh = 4'b0001;
      ColorGreen:  oh = 4'b0010;
      ColorBlue:   oh = 4'b0100;
      ColorYellow: oh = 4'b1000;
      default:     oh = 4'b0000;
    endcase
    return oh;
  endfunction

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_step_timer.sv
// Loadable down-counter with a zero flag; times both the SHOW and GAP phases.
module seq_step_timer #(
  parameter int unsigned Width = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seq_playback_ctrl.sv
// Plays back a stored color sequence on four lamps, one step at a time.
// Optional build macro SEQ_PLAYBACK_STEP_OUT_EN adds the step_o index output.
// COLOR_CODEFY_W must be at least 2; only the low two bits select a lamp.
module seq_playback_ctrl
  import seq_playback_ctrl_pkg::*;
#(
  parameter int unsigned COLOR_CODEFY_W = 2,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned ON_SLOW        = 8,
  parameter int unsigned ON_FAST        = 4,
  parameter int unsigned GAP_CYC        = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [ADDR_WIDTH-1:0]     play_len_i,
  input  logic                      speed_i,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  input  logic [COLOR_CODEFY_W-1:0] mem_rdata_i,
  output logic                      led_red_o,
  output logic                      led_green_o,
  output logic                      led_blue_o,
  output logic                      led_yellow_o,
  output logic                      busy_o,
  output logic                      done_o
`ifdef SEQ_PLAYBACK_STEP_OUT_EN
  ,
  output logic [ADDR_WIDTH-1:0]     step_o
`endif
);

  localparam int unsigned TmrMax = max3(ON_SLOW, ON_FAST, GAP_CYC);
  localparam int unsigned TmrW   = (TmrMax > 1) ? $clog2(TmrMax) : 1;

  // The timer holds "cycles remaining after this one", hence the minus one.
  localparam logic [TmrW-1:0] OnSlowM1 = TmrW'(ON_SLOW - 1);
  localparam logic [TmrW-1:0] OnFastM1 = TmrW'(ON_FAST - 1);
  localparam logic [TmrW-1:0] GapM1    = TmrW'(GAP_CYC - 1);

  state_e                    state_q;
  logic [ADDR_WIDTH-1:0]     idx_q;
  logic [ADDR_WIDTH-1:0]     len_q;
  logic                      speed_q;
  logic [COLOR_CODEFY_W-1:0] color_q;

  logic            tmr_load;
  logic [TmrW-1:0] tmr_val;
  logic            tmr_zero;
  logic [3:0]      led_vec;

  seq_step_timer #(
    .Width (TmrW)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Timer reload: on-count entering SHOW, gap count entering GAP, cleared on abort.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (abort_i) begin
      tmr_load = 1'b1;
    end else if (state_q == StLatch) begin
      tmr_load = 1'b1;
      tmr_val  = speed_q ? OnFastM1 : OnSlowM1;
    end else if ((state_q == StShow) && tmr_zero) begin
      tmr_load = 1'b1;
      tmr_val  = GapM1;
    end
  end

  // Playback sequencer; abort overrides every state including a pending start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      len_q   <= '0;
      speed_q <= 1'b0;
      color_q <= '0;
    end else if (abort_i) begin
      state_q <= StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StFetch;
            idx_q   <= '0;
            len_q   <= play_len_i;
            speed_q <= speed_i;
          end
        end
        StFetch: state_q <= StLatch;
        StLatch: begin
          color_q <= mem_rdata_i;
          state_q <= StShow;
        end
        StShow: begin
          if (tmr_zero) state_q <= StGap;
        end
        StGap: begin
          if (tmr_zero) begin
            if (idx_q == len_q) begin
              state_q <= StDone;
            end else begin
              idx_q   <= idx_q + ADDR_WIDTH'(1);
              state_q <= StFetch;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign led_vec      = (state_q == StShow) ? color_onehot(color_t'(color_q[1:0])) : 4'b0000;
  assign led_red_o    = led_vec[0];
  assign led_green_o  = led_vec[1];
  assign led_blue_o   = led_vec[2];
  assign led_yellow_o = led_vec[3];
  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone);
  assign mem_addr_o   = busy_o ? idx_q : '0;

`ifdef SEQ_PLAYBACK_STEP_OUT_EN
  assign step_o = busy_o ? idx_q : '0;
`else
  // Step index stays internal; mem_addr_o already carries it during playback.
`endif

endmodule

// File: tb/tb_seq_playback_ctrl.sv
// Self-checking bench for seq_playback_ctrl against a cycle-offset reference model.
module tb_seq_playback_ctrl;

  localparam int CW  = 2;
  localparam int AW  = 5;
  localparam int ONS = 8;
  localparam int ONF = 4;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          speed_i = 1'b0;
  logic [AW-1:0] play_len_i = '0;
  logic [AW-1:0] mem_addr_o;
  logic [CW-1:0] mem_rdata_i;
  logic          led_red_o, led_green_o, led_blue_o, led_yellow_o;
  logic          busy_o, done_o;
`ifdef SEQ_PLAYBACK_STEP_OUT_EN
  logic [AW-1:0] step_o;
`endif

  logic [1:0] mem [32];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  // Reference model: playback described by start cycle, length and on-count.
  bit m_active = 1'b0;
  int m_t0 = 0;
  int m_len = 0;
  int m_on = 0;

  always #5 clk = ~clk;

  seq_playback_ctrl #(
    .COLOR_CODEFY_W (CW),
    .ADDR_WIDTH     (AW),
    .ON_SLOW        (ONS),
    .ON_FAST        (ONF),
    .GAP_CYC        (GAP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .play_len_i   (play_len_i),
    .speed_i      (speed_i),
    .mem_addr_o   (mem_addr_o),
    .mem_rdata_i  (mem_rdata_i),
    .led_red_o    (led_red_o),
    .led_green_o  (led_green_o),
    .led_blue_o   (led_blue_o),
    .led_yellow_o (led_yellow_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
`ifdef SEQ_PLAYBACK_STEP_OUT_EN
    ,
    .step_o       (step_o)
`endif
  );

  // Synchronous memory: data for an address appears one cycle later.
  always @(posedge clk) mem_rdata_i <= mem[mem_addr_o];

  // Model update at each active edge (inputs are stable there).
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_active = 1'b0;
    end else begin
      if (abort_i) begin
        m_active = 1'b0;
      end else if (!m_active) begin
        if (start_i) begin
          m_active = 1'b1;
          m_t0     = cyc;
          m_len    = int'(play_len_i);
          m_on     = speed_i ? ONF : ONS;
        end
      end else if (cyc - m_t0 == (m_len + 1) * (2 + m_on + GAP) + 1) begin
        m_active = 1'b0;
      end
      cyc++;
    end
  end

  int         c_off, p_len, s_idx, r_off;
  logic       e_busy, e_done;
  logic [AW-1:0] e_addr;
  logic [3:0] e_led;
  logic [10:0] got_v, exp_v;

  // Per-cycle compare of every output against the model.
  initial forever begin
    @(negedge clk);
    e_busy = 1'b0;
    e_done = 1'b0;
    e_addr = '0;
    e_led  = 4'b0000;
    if (m_active) begin
      c_off  = cyc - m_t0;
      p_len  = 2 + m_on + GAP;
      e_busy = 1'b1;
      if (c_off == (m_len + 1) * p_len + 1) begin
        e_done = 1'b1;
        e_addr = AW'(m_len);
      end else begin
        s_idx  = (c_off - 1) / p_len;
        r_off  = (c_off - 1) % p_len;
        e_addr = AW'(s_idx);
        if (r_off >= 2 && r_off < 2 + m_on) e_led = 4'b0001 << mem[s_idx];
      end
    end
    got_v = {busy_o, done_o, mem_addr_o, led_yellow_o, led_blue_o, led_green_o, led_red_o};
    exp_v = {e_busy, e_done, e_addr, e_led};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL model_cmp cyc=%0d got busy,done,addr,ylw-blu-grn-red=%b required %b",
               cyc, got_v, exp_v);
    end
`ifdef SEQ_PLAYBACK_STEP_OUT_EN
    checks++;
    if (step_o !== e_addr) begin
      errors++;
      $display("FAIL step_o cyc=%0d got %0d required %0d", cyc, step_o, e_addr);
    end
`endif
    if (done_o === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] len, input logic spd);
    play_len_i = len;
    speed_i    = spd;
    start_i    = 1'b1;
    tick();
    start_i    = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy_o !== 1'b0 && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout busy_o got %b required 0", name, busy_o);
    end
  endtask

  int d0, donec, n_r, n_g, n_b, n_y;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    // Reset state, both during and just after reset.
    check_lit("rst_busy", int'(busy_o), 0);
    check_lit("rst_leds", int'({led_yellow_o, led_blue_o, led_green_o, led_red_o}), 0);
    check_lit("rst_addr", int'(mem_addr_o), 0);
    rst_n = 1'b1;
    tick();
    check_lit("post_rst_done", int'(done_o), 0);

    // Single fast blue step.
    mem[0] = 2'b10;
    d0 = done_cnt;
    pulse_start(5'd0, 1'b1);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      check_lit("t1_blue", int'(led_blue_o), (c >= 3 && c <= 6) ? 1 : 0);
      check_lit("t1_done", int'(done_o), (c == 9) ? 1 : 0);
    end
    tick();
    check_lit("t1_done_cnt", done_cnt - d0, 1);

    // Four slow steps red, green, blue, yellow.
    mem[0] = 2'b00; mem[1] = 2'b01; mem[2] = 2'b10; mem[3] = 2'b11;
    d0 = done_cnt; donec = 0; n_r = 0; n_g = 0; n_b = 0; n_y = 0;
    pulse_start(5'd3, 1'b0);
    for (int c = 1; c <= 52; c++) begin
      @(negedge clk);
      n_r += int'(led_red_o); n_g += int'(led_green_o);
      n_b += int'(led_blue_o); n_y += int'(led_yellow_o);
      if (done_o === 1'b1) donec = c;
      tick();
    end
    check_lit("t2_red_cycles", n_r, 8);
    check_lit("t2_green_cycles", n_g, 8);
    check_lit("t2_blue_cycles", n_b, 8);
    check_lit("t2_yellow_cycles", n_y, 8);
    check_lit("t2_done_cycle", donec, 49);
    check_lit("t2_done_cnt", done_cnt - d0, 1);

    // Abort on the second SHOW cycle of step 1.
    d0 = done_cnt;
    pulse_start(5'd3, 1'b0);
    repeat (15) tick();
    check_lit("t3_green_before_abort", int'(led_green_o), 1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    @(negedge clk);
    check_lit("t3_busy_after_abort", int'(busy_o), 0);
    check_lit("t3_leds_after_abort",
              int'({led_yellow_o, led_blue_o, led_green_o, led_red_o}), 0);
    repeat (20) tick();
    check_lit("t3_no_done", done_cnt - d0, 0);

    // Restart attempts in GAP plus speed/length churn must not disturb a fast run.
    d0 = done_cnt; donec = 0;
    pulse_start(5'd2, 1'b1);
    for (int c = 1; c <= 30; c++) begin
      start_i    = (c == 7 || c == 8) ? 1'b1 : 1'b0;
      speed_i    = ~speed_i;
      play_len_i = AW'($urandom);
      @(negedge clk);
      if (done_o === 1'b1) donec = c;
      tick();
    end
    start_i = 1'b0;
    check_lit("t4_done_cycle", donec, 25);
    check_lit("t4_done_cnt", done_cnt - d0, 1);

    // Full 32-step sequence without index wrap.
    for (int i = 0; i < 32; i++) mem[i] = 2'(i);
    d0 = done_cnt;
    pulse_start(5'd31, 1'b1);
    wait_idle("t5");
    check_lit("t5_done_cnt", done_cnt - d0, 1);

    // Asynchronous reset in the middle of SHOW.
    mem[0] = 2'b11;
    d0 = done_cnt;
    pulse_start(5'd2, 1'b0);
    repeat (3) tick();
    check_lit("t6_yellow_before_rst", int'(led_yellow_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_lit("t6_busy_in_rst", int'(busy_o), 0);
    check_lit("t6_leds_in_rst", int'({led_yellow_o, led_blue_o, led_green_o, led_red_o}), 0);
`ifdef SEQ_PLAYBACK_STEP_OUT_EN
    check_lit("t6_step_in_rst", int'(step_o), 0);
`endif
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (30) tick();
    check_lit("t6_no_done", done_cnt - d0, 0);
    check_lit("t6_idle_after_rst", int'(busy_o), 0);
    d0 = done_cnt;
    pulse_start(5'd1, 1'b1);
    wait_idle("t6_rerun");
    check_lit("t6_rerun_done_cnt", done_cnt - d0, 1);

    // Randomized traffic; memory is only rewritten while idle.
    for (int rnd = 0; rnd < 6; rnd++) begin
      for (int i = 0; i < 32; i++) mem[i] = 2'($urandom);
      for (int n = 0; n < 400; n++) begin
        start_i    = ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0;
        abort_i    = ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0;
        speed_i    = 1'($urandom);
        play_len_i = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 4));
        tick();
      end
      start_i = 1'b0;
      abort_i = 1'b0;
      wait_idle("rand");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
